// File: rtl/pcie_stp_sdp_detect.sv
// ---------------------------------------------------------------------------
// pcie_stp_sdp_detect
//   Receive-side framing parser for an 8b/10b PCIe link. Each cycle it scans
//   the descrambled lane symbols in lane order for STP, SDP, END and EDB. It
//   carries the packet state across lanes and cycles, measures packet length
//   and flags framing violations. All outputs are registered, so results
//   appear one cycle after the in_valid cycle.
//
// Ports
//   clk, rst_n    core clock, asynchronous active-low reset
//   in_valid      data_in/k_in qualify this cycle
//   data_in       lane n symbol at [8n+:8], lane 0 first in time
//   k_in          bit n set = lane n carries a K symbol
//   out_valid     registered in_valid
//   data_out      registered data_in
//   start_valid   first accepted STP/SDP of the cycle
//   start_dllp    1 = SDP, 0 = STP
//   start_lane    lane of the reported start token
//   end_valid     first accepted END/EDB of the cycle
//   end_bad       1 = EDB (nullified TLP)
//   end_lane      lane of the reported end token
//   pkt_len       closing length, both tokens included
//   in_packet     packet still open after the last lane
//   framing_err   at least one framing error this cycle
//   err_count     saturating count of framing-error cycles
// ---------------------------------------------------------------------------
module pcie_stp_sdp_detect #(
   parameter  int LINK_WIDTH = 16,
   localparam int LW         = $clog2(LINK_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [8*LINK_WIDTH-1:0] data_in,
   input  logic [LINK_WIDTH-1:0]   k_in,
   output logic                    out_valid,
   output logic [8*LINK_WIDTH-1:0] data_out,
   output logic                    start_valid,
   output logic                    start_dllp,
   output logic [LW-1:0]           start_lane,
   output logic                    end_valid,
   output logic                    end_bad,
   output logic [LW-1:0]           end_lane,
   output logic [11:0]             pkt_len,
   output logic                    in_packet,
   output logic                    framing_err,
   output logic [7:0]              err_count
);

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_SDP = 8'h5C;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_IN_TLP  = 2'd1;
   localparam logic [1:0] S_IN_DLLP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [11:0] len_q, len_d;

   // per-cycle scan results
   logic          sv_d, sd_d, ev_d, eb_d, err_d;
   logic [LW-1:0] sl_d, el_d;
   logic [11:0]   plen_d;

   logic          out_valid_q, start_valid_q, start_dllp_q, end_valid_q, end_bad_q;
   logic          in_packet_q, framing_err_q;
   logic [LW-1:0] start_lane_q, end_lane_q;
   logic [11:0]   pkt_len_q;
   logic [7:0]    err_count_q;
   logic [8*LINK_WIDTH-1:0] data_out_q;

   // Unrolled lane scan. 'stop' models "ignore the rest of the cycle" after
   // an error; only the first start and first end of a cycle are reported,
   // but later tokens still drive state and length.
   always_comb begin
      logic [7:0] sym;
      logic       is_start, is_end, stop;
      state_d  = state_q;
      len_d    = len_q;
      sv_d     = 1'b0;
      sd_d     = 1'b0;
      sl_d     = '0;
      ev_d     = 1'b0;
      eb_d     = 1'b0;
      el_d     = '0;
      plen_d   = '0;
      err_d    = 1'b0;
      stop     = 1'b0;
      sym      = '0;
      is_start = 1'b0;
      is_end   = 1'b0;
      for (int i = 0; i < LINK_WIDTH; i++) begin
         sym      = data_in[8*i +: 8];
         is_start = k_in[i] && (sym == K_STP || sym == K_SDP);
         is_end   = k_in[i] && (sym == K_END || sym == K_EDB);
         if (!stop) begin
            if (state_d == S_IDLE) begin
               if (is_start) begin
                  if ((i % 4) != 0) begin
                     err_d = 1'b1;
                     stop  = 1'b1;
                  end else begin
                     state_d = (sym == K_SDP) ? S_IN_DLLP : S_IN_TLP;
                     len_d   = 12'd1;
                     if (!sv_d) begin
                        sv_d = 1'b1;
                        sd_d = (sym == K_SDP);
                        sl_d = LW'(i);
                     end
                  end
               end else if (is_end) begin
                  err_d = 1'b1;
                  stop  = 1'b1;
               end
               // data and other K symbols between packets are ignored
            end else begin
               // length counts this lane before any end check, so the
               // closing length includes the end token itself
               if (len_d != 12'hFFF) len_d = len_d + 12'd1;
               if (is_start) begin
                  err_d = 1'b1;
                  stop  = 1'b1;
               end else if (is_end) begin
                  if (sym == K_EDB) begin
                     // EDB nullifies a TLP of any length; never legal on a DLLP
                     if (state_d == S_IN_TLP) begin
                        if (!ev_d) begin
                           ev_d   = 1'b1;
                           eb_d   = 1'b1;
                           el_d   = LW'(i);
                           plen_d = len_d;
                        end
                        state_d = S_IDLE;
                     end else begin
                        err_d = 1'b1;
                        stop  = 1'b1;
                     end
                  end else if ((state_d == S_IN_DLLP && len_d == 12'd8) ||
                               (state_d == S_IN_TLP && len_d[1:0] == 2'b00 && len_d >= 12'd20)) begin
                     if (!ev_d) begin
                        ev_d   = 1'b1;
                        eb_d   = 1'b0;
                        el_d   = LW'(i);
                        plen_d = len_d;
                     end
                     state_d = S_IDLE;
                  end else begin
                     err_d = 1'b1;
                     stop  = 1'b1;
                  end
               end else if (k_in[i]) begin
                  err_d = 1'b1;
                  stop  = 1'b1;
               end
            end
            if (stop) state_d = S_IDLE;
         end
      end
      if (state_d == S_IDLE) len_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         len_q         <= '0;
         out_valid_q   <= 1'b0;
         data_out_q    <= '0;
         start_valid_q <= 1'b0;
         start_dllp_q  <= 1'b0;
         start_lane_q  <= '0;
         end_valid_q   <= 1'b0;
         end_bad_q     <= 1'b0;
         end_lane_q    <= '0;
         pkt_len_q     <= '0;
         in_packet_q   <= 1'b0;
         framing_err_q <= 1'b0;
         err_count_q   <= '0;
      end else begin
         out_valid_q <= in_valid;
         data_out_q  <= data_in;
         if (in_valid) begin
            state_q       <= state_d;
            len_q         <= len_d;
            start_valid_q <= sv_d;
            start_dllp_q  <= sd_d;
            start_lane_q  <= sl_d;
            end_valid_q   <= ev_d;
            end_bad_q     <= eb_d;
            end_lane_q    <= el_d;
            pkt_len_q     <= plen_d;
            in_packet_q   <= (state_d != S_IDLE);
            framing_err_q <= err_d;
            if (err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
         end else begin
            // idle cycle: no events, packet state and in_packet hold
            start_valid_q <= 1'b0;
            end_valid_q   <= 1'b0;
            framing_err_q <= 1'b0;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign data_out    = data_out_q;
   assign start_valid = start_valid_q;
   assign start_dllp  = start_dllp_q;
   assign start_lane  = start_lane_q;
   assign end_valid   = end_valid_q;
   assign end_bad     = end_bad_q;
   assign end_lane    = end_lane_q;
   assign pkt_len     = pkt_len_q;
   assign in_packet   = in_packet_q;
   assign framing_err = framing_err_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_pcie_stp_sdp_detect.sv
// Scoreboard bench for pcie_stp_sdp_detect (x16). Stimulus pushes the
// hand-computed response of each driven cycle; the monitor pops one entry
// every cycle the DUT shows out_valid.
module tb_pcie_stp_sdp_detect;
   localparam int NL = 16;
   localparam int LW = 4;
   localparam logic [7:0] STP = 8'hFB, SDP = 8'h5C, ENDS = 8'hFD, EDB = 8'hFE;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [8*NL-1:0]   data_in = '0;
   logic [NL-1:0]     k_in = '0;
   logic              out_valid, start_valid, start_dllp, end_valid, end_bad;
   logic              in_packet, framing_err;
   logic [8*NL-1:0]   data_out;
   logic [LW-1:0]     start_lane, end_lane;
   logic [11:0]       pkt_len;
   logic [7:0]        err_count;

   pcie_stp_sdp_detect #(.LINK_WIDTH(NL)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in), .k_in(k_in),
      .out_valid(out_valid), .data_out(data_out), .start_valid(start_valid),
      .start_dllp(start_dllp), .start_lane(start_lane), .end_valid(end_valid),
      .end_bad(end_bad), .end_lane(end_lane), .pkt_len(pkt_len), .in_packet(in_packet),
      .framing_err(framing_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sv, sd;
      logic [3:0]  sl;
      logic        ev, eb;
      logic [3:0]  el;
      logic [11:0] len;
      logic        inpkt, ferr;
      logic [7:0]  ec;
      logic [8*NL-1:0] data;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int ec = 0;   // expected err_count, stepped by hand where errors are planted

   logic [8*NL-1:0] dv;
   logic [NL-1:0]   kv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // lanes default to distinct D symbols
   task automatic clr();
      for (int i = 0; i < NL; i++) dv[8*i +: 8] = 8'(i * 7 + 1);
      kv = '0;
   endtask

   task automatic setk(input int lane, input logic [7:0] sym);
      dv[8*lane +: 8] = sym;
      kv[lane] = 1'b1;
   endtask

   function automatic exp_t mk(input logic sv, input logic sd, input int sl,
                               input logic ev, input logic eb, input int el, input int len,
                               input logic inpkt, input logic ferr);
      exp_t e;
      e.sv = sv; e.sd = sd; e.sl = 4'(sl);
      e.ev = ev; e.eb = eb; e.el = 4'(el); e.len = 12'(len);
      e.inpkt = inpkt; e.ferr = ferr;
      if (ferr && ec < 255) ec++;
      e.ec = 8'(ec);
      e.data = '0;
      return e;
   endfunction

   task automatic send(input exp_t e);
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = dv;
      k_in     = kv;
      e.data   = dv;
      q.push_back(e);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_out_valid actual=1 expected=0");
            end else begin
               e = q.pop_front();
               chk("start_valid", 32'(start_valid), 32'(e.sv));
               if (e.sv) begin
                  chk("start_dllp", 32'(start_dllp), 32'(e.sd));
                  chk("start_lane", 32'(start_lane), 32'(e.sl));
               end
               chk("end_valid", 32'(end_valid), 32'(e.ev));
               if (e.ev) begin
                  chk("end_bad", 32'(end_bad), 32'(e.eb));
                  chk("end_lane", 32'(end_lane), 32'(e.el));
                  chk("pkt_len", 32'(pkt_len), 32'(e.len));
               end
               chk("in_packet", 32'(in_packet), 32'(e.inpkt));
               chk("framing_err", 32'(framing_err), 32'(e.ferr));
               chk("err_count", 32'(err_count), 32'(e.ec));
               checks++;
               if (data_out !== e.data) begin
                  failures++;
                  $display("FAIL data_out actual=%h expected=%h", data_out, e.data);
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_events"}, 32'({start_valid, start_dllp, end_valid, end_bad, framing_err}), 0);
      chk({tag, "_lanes_len"}, 32'({start_lane, end_lane, pkt_len}), 0);
      chk({tag, "_in_packet"}, 32'(in_packet), 0);
      chk({tag, "_err_count"}, 32'(err_count), 0);
      chk({tag, "_data_out"}, 32'(|data_out), 0);
   endtask

   initial begin
      // reset state
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: DLLP inside one cycle
      clr(); setk(0, SDP); setk(7, ENDS);
      send(mk(1, 1, 0, 1, 0, 7, 8, 0, 0));

      // 2: TLP spanning two cycles, 24 symbols
      clr(); setk(4, STP);
      send(mk(1, 0, 4, 0, 0, 0, 0, 1, 0));
      clr(); setk(11, ENDS);
      send(mk(0, 0, 0, 1, 0, 11, 24, 0, 0));

      // 3: misaligned STP; remaining lanes of the cycle are ignored
      clr(); setk(2, STP); setk(4, SDP); setk(11, ENDS);
      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

      // 4: TLP len 22 closed by END (error) and by EDB (nullified)
      clr(); setk(0, STP);
      send(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      clr(); setk(5, ENDS);
      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      clr(); setk(0, STP);
      send(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      clr(); setk(5, EDB);
      send(mk(0, 0, 0, 1, 1, 5, 22, 0, 0));

      // two DLLPs in one cycle: only the first of each token is reported
      clr(); setk(0, SDP); setk(7, ENDS); setk(8, SDP); setk(15, ENDS);
      send(mk(1, 1, 0, 1, 0, 7, 8, 0, 0));

      // stray K inside a TLP
      clr(); setk(0, STP); setk(3, 8'h1C);
      send(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
      // start while in a packet
      clr(); setk(0, STP); setk(4, STP);
      send(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
      // short DLLP
      clr(); setk(0, SDP); setk(5, ENDS);
      send(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
      // END while idle
      clr(); setk(0, ENDS);
      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      // EDB on a DLLP
      clr(); setk(0, SDP); setk(7, EDB);
      send(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));

      // 5: END lane 3 closes TLP of 28, STP lane 4 opens the next
      clr(); setk(8, STP);
      send(mk(1, 0, 8, 0, 0, 0, 0, 1, 0));
      clr();
      send(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      clr(); setk(3, ENDS); setk(4, STP);
      send(mk(1, 0, 4, 1, 0, 3, 28, 1, 0));

      // drop in_valid mid-packet: no output, state held
      @(negedge clk);
      in_valid = 1'b0;
      clr(); setk(0, ENDS); data_in = dv; k_in = kv;
      @(negedge clk);
      chk("drop_out_valid", 32'(out_valid), 0);
      chk("drop_events", 32'({start_valid, end_valid, framing_err}), 0);
      chk("drop_in_packet", 32'(in_packet), 1);
      chk("drop_err_count", 32'(err_count), 32'(ec));
      // resume: length continues from 12
      clr(); setk(0, EDB);
      send(mk(0, 0, 0, 1, 1, 0, 13, 0, 0));

      // 6: err_count saturation
      for (int n = 0; n < 300; n++) begin
         clr(); setk(2, STP);
         send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      end

      // async reset mid-packet
      clr(); setk(0, STP);
      send(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      ec = 0;
      // the discarded packet left the parser idle, so END is an error
      clr(); setk(0, ENDS);
      send(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      in_valid = 1'b0;

      // bounded drain
      for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
